slot_bank_arbiter: RTL and testbench
====================================

# slot_bank_arbiter

Write-port controller for the 3-slot, 4-bit value bank. Shares the bank's single write port among NREQ requesters (debounced/edge-detected load sources), allocates the lowest free slot to each accepted write, and sequences the bank between FILL and COMBINE modes. A clear request empties the bank. The block sits between the button front-ends (edge detector, debouncer) and the value bank/combine logic.

## Interface
- NREQ, 3, number of requesters (2..4)
- WIDTH, 4, data word width
- SLOTS, 3, bank depth (2..4); slot index width is 2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  level write request per requester; held with its data until granted
- wdata  in  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- clr  in  1  single-cycle clear pulse (already edge-detected)
- gnt  out  NREQ  one-hot grant, combinational, same cycle as accept
- wr_en  out  1  registered bank write strobe
- wr_slot  out  2  registered slot index for the write
- wr_data  out  WIDTH  registered write data
- bank_clr  out  1  registered bank clear strobe
- mode  out  1  0 = FILL, 1 = COMBINE (registered)
- fill_cnt  out  3  number of valid slots (registered)

## Operation
- States: FILL (0), COMBINE (1), CLEAR (2). Reset → FILL.
- FILL: if clr=0 and any req, pick one requester, assert its gnt bit; at the clock edge set valid[s] for s = lowest index with valid[s]=0, capture wdata of grantee into wr_data, wr_slot=s, wr_en=1 for one cycle.
- Requester handshake: write accepted in the cycle req[i]&gnt[i]=1; requester drops or changes req/data from the next cycle. req held without gnt is never lost.
- If the accepted write fills the last free slot, next state COMBINE.
- COMBINE: gnt=0 for all; req ignored (stays pending); mode=1.
- clr=1 in FILL or COMBINE: gnt=0 that cycle, next state CLEAR. clr wins over simultaneous req.
- CLEAR (one cycle): bank_clr=1, valid cleared, fill_cnt→0, arbitration pointer → NREQ-1; next state FILL. clr during CLEAR ignored.
- Data value 0 is a legal write; occupancy is tracked by valid bits, not data.

## Timing
- Reset values: gnt=0, wr_en=0, wr_slot=0, wr_data=0, bank_clr=0, mode=0, fill_cnt=0, valid=0, pointer=NREQ-1.
- gnt: zero-latency combinational from req, state, clr.
- wr_en/wr_slot/wr_data, fill_cnt: valid the cycle after the grant cycle.
- mode=1 the cycle after the filling grant; first cycle in COMBINE has gnt=0.
- bank_clr high the cycle after clr sampled; FILL grants resume the following cycle.
- Max throughput: one write per cycle. Reset mid-write discards the pending write.

## Configuration
- SLOT_ARB_RR_EN defined: round-robin; search starts at (last grantee + 1) mod NREQ; pointer updates only on an accepted grant.
- Not defined: fixed priority, req[0] highest; pointer unused.

## Structure
- Package slot_arb_pkg: state localparams (ST_FILL, ST_COMBINE, ST_CLEAR), default WIDTH/SLOTS/NREQ, slot index width.
- One sub-module rr_pick: given req vector and start index, returns one-hot grant (start=0 yields fixed priority).

## Test plan
- Reset, then req=3'b001 wdata0=4'h5 → gnt=001 same cycle; next cycle wr_en=1, wr_slot=0, wr_data=5, fill_cnt=1.
- req=3'b111 held, RR build → grants 0,1,2 on consecutive cycles, slots 0,1,2; mode=1 after third; fixed-priority build → grant 0 three times.
- In COMBINE, req=3'b010 held → gnt stays 0; clr pulse → bank_clr next cycle, fill_cnt=0, mode=0, then gnt=010.
- clr and req=3'b001 same cycle in FILL → gnt=0, no wr_en, CLEAR entered.
- Write 4'h0 to slot 0 → fill_cnt=1, next write lands in slot 1.
- Assert rst_n low mid-fill (fill_cnt=2) → all outputs 0 asynchronously, next grant writes slot 0.

Source files
------------

// File: rtl/slot_bank_arbiter_pkg.sv
// Shared types and defaults for the slot bank write-port arbiter.
// Package name is slot_arb_pkg; imported by slot_bank_arbiter and rr_pick.
package slot_arb_pkg;

    localparam int NREQ_DEF   = 3;
    localparam int WIDTH_DEF  = 4;
    localparam int SLOTS_DEF  = 3;
    localparam int SLOT_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_COMBINE = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

    // Index of the lowest zero bit; callers pad unused upper bits with ones.
    function automatic logic [SLOT_IDX_W-1:0] lowest_zero(input logic [3:0] v);
        lowest_zero = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) lowest_zero = SLOT_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/slot_bank_arbiter_rr_pick.sv
// One-hot picker: first asserted request at or after i_start, wrapping.
// With i_start tied to zero this degenerates to fixed priority (bit 0 highest).
module rr_pick
    import slot_arb_pkg::*;
#(
    parameter int N = NREQ_DEF
) (
    input  logic [N-1:0]          i_req,
    input  logic [SLOT_IDX_W-1:0] i_start,
    output logic [N-1:0]          o_gnt,
    output logic [SLOT_IDX_W-1:0] o_idx
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(i_start) + k) % N]) begin
                w_found = 1'b1;
                o_idx   = SLOT_IDX_W'((int'(i_start) + k) % N);
                o_gnt[(int'(i_start) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slot_bank_arbiter.sv
// Write-port arbiter and FILL/COMBINE/CLEAR sequencer for the slot value bank.
// Define SLOT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
//
// state      | meaning
// ST_FILL    | granting writes into the lowest free slot
// ST_COMBINE | bank full, requests held off until a clear
// ST_CLEAR   | one-cycle bank clear strobe, then back to FILL
module slot_bank_arbiter
    import slot_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLOTS = SLOTS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*WIDTH-1:0]   i_wdata,
    input  logic                    i_clr,
    output logic [NREQ-1:0]         o_gnt,
    output logic                    o_wr_en,
    output logic [SLOT_IDX_W-1:0]   o_wr_slot,
    output logic [WIDTH-1:0]        o_wr_data,
    output logic                    o_bank_clr,
    output logic                    o_mode,
    output logic [2:0]              o_fill_cnt
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SLOTS-1:0]        r_valid;
    logic [2:0]              r_fill_cnt;
    logic                    r_wr_en;
    logic [SLOT_IDX_W-1:0]   r_wr_slot;
    logic [WIDTH-1:0]        r_wr_data;
    logic                    r_bank_clr;
    logic                    r_mode;

    logic [NREQ-1:0]         w_pick_gnt;
    logic [SLOT_IDX_W-1:0]   w_pick_idx;
    logic [SLOT_IDX_W-1:0]   w_start;
    logic [NREQ-1:0]         w_gnt;
    logic                    w_accept;
    logic                    w_last_slot;
    logic                    w_clr_take;
    logic [3:0]              w_valid_pad;
    logic [SLOT_IDX_W-1:0]   w_free_slot;
    logic [WIDTH-1:0]        w_data;

`ifdef SLOT_ARB_RR_EN
    logic [SLOT_IDX_W-1:0]   r_ptr;

    assign w_start = (r_ptr == SLOT_IDX_W'(NREQ - 1)) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SLOT_IDX_W'(NREQ - 1);
        end else if (w_clr_take) begin
            r_ptr <= SLOT_IDX_W'(NREQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_pick_idx;
        end
    end
`else
    assign w_start = '0;
`endif

    rr_pick #(
        .N (NREQ)
    ) u_pick (
        .i_req   (i_req),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_valid_pad              = '1;
        w_valid_pad[SLOTS-1:0]   = r_valid;
    end

    assign w_free_slot = lowest_zero(w_valid_pad);
    assign w_last_slot = (r_fill_cnt == 3'(SLOTS - 1));
    assign w_data      = i_wdata[int'(w_pick_idx)*WIDTH +: WIDTH];
    assign w_accept    = |w_gnt;
    // A clear is only honoured outside CLEAR; a repeat pulse there is dropped.
    assign w_clr_take  = i_clr && (r_state != ST_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_gnt        = '0;
        case (r_state)
            ST_FILL: begin
                if (i_clr) begin
                    w_next_state = ST_CLEAR;
                end else begin
                    w_gnt = w_pick_gnt;
                    if ((|w_pick_gnt) && w_last_slot) w_next_state = ST_COMBINE;
                end
            end
            ST_COMBINE: begin
                if (i_clr) w_next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_next_state = ST_FILL;
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_fill_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_slot  <= '0;
            r_wr_data  <= '0;
            r_bank_clr <= 1'b0;
            r_mode     <= 1'b0;
        end else begin
            r_wr_en    <= w_accept;
            r_bank_clr <= w_clr_take;
            r_mode     <= (w_next_state == ST_COMBINE);
            // Occupancy drops on the clr edge so fill_cnt reads 0 alongside bank_clr.
            if (w_clr_take) begin
                r_valid    <= '0;
                r_fill_cnt <= '0;
            end else if (w_accept) begin
                r_valid[w_free_slot] <= 1'b1;
                r_fill_cnt           <= r_fill_cnt + 3'd1;
                r_wr_slot            <= w_free_slot;
                r_wr_data            <= w_data;
            end
        end
    end

    assign o_gnt      = w_gnt;
    assign o_wr_en    = r_wr_en;
    assign o_wr_slot  = r_wr_slot;
    assign o_wr_data  = r_wr_data;
    assign o_bank_clr = r_bank_clr;
    assign o_mode     = r_mode;
    assign o_fill_cnt = r_fill_cnt;

endmodule

// File: tb/tb_slot_bank_arbiter.sv
// Scoreboard bench for slot_bank_arbiter: directed sequences plus random requesters.
module tb_slot_bank_arbiter;

    localparam int N = 3;
    localparam int W = 4;
    localparam int S = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     i_req;
    logic [N*W-1:0]   i_wdata;
    logic             i_clr;
    logic [N-1:0]     o_gnt;
    logic             o_wr_en;
    logic [1:0]       o_wr_slot;
    logic [W-1:0]     o_wr_data;
    logic             o_bank_clr;
    logic             o_mode;
    logic [2:0]       o_fill_cnt;

    slot_bank_arbiter #(.NREQ(N), .WIDTH(W), .SLOTS(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_wdata    (i_wdata),
        .i_clr      (i_clr),
        .o_gnt      (o_gnt),
        .o_wr_en    (o_wr_en),
        .o_wr_slot  (o_wr_slot),
        .o_wr_data  (o_wr_data),
        .o_bank_clr (o_bank_clr),
        .o_mode     (o_mode),
        .o_fill_cnt (o_fill_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int slot;
        int data;
        int cnt;
        int mode;
    } wr_t;

    wr_t q_wr[$];
    int  q_clr[$];

    // Reference: bank as an occupancy array, mode as 0 fill / 1 combine / 2 clear.
    int m_mode;
    int m_valid[S];
    int m_cnt;
    int m_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_last = N - 1;
        for (int i = 0; i < S; i++) m_valid[i] = 0;
    endtask

    task automatic issue(input logic [N-1:0] rq, input logic [N*W-1:0] wd,
                         input logic c, output int g);
        int idx;
        int slot;
        int d;
        @(negedge clk);
        i_req   = rq;
        i_wdata = wd;
        i_clr   = c;
        #1;
        g = -1;
        if (m_mode == 0 && !c) begin
            for (int k = 0; k < N; k++) begin
`ifdef SLOT_ARB_RR_EN
                idx = (m_last + 1 + k) % N;
`else
                idx = k;
`endif
                if (g < 0 && rq[idx]) g = idx;
            end
        end
        check("gnt", int'(o_gnt), (g < 0) ? 0 : (1 << g));
        check("mode", int'(o_mode), (m_mode == 1) ? 1 : 0);
        check("fill_cnt", int'(o_fill_cnt), m_cnt);
        if (m_mode == 2) begin
            m_mode = 0;
        end else if (c) begin
            for (int i = 0; i < S; i++) m_valid[i] = 0;
            m_cnt  = 0;
            m_last = N - 1;
            m_mode = 2;
            q_clr.push_back(cyc + 1);
        end else if (g >= 0) begin
            slot = -1;
            for (int i = 0; i < S; i++) if (slot < 0 && m_valid[i] == 0) slot = i;
            m_valid[slot] = 1;
            m_cnt++;
            d = int'(wd[g*W +: W]);
            m_last = g;
            if (m_cnt == S) m_mode = 1;
            q_wr.push_back('{cyc + 1, slot, d, m_cnt, (m_mode == 1) ? 1 : 0});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, int'(o_gnt), 0);
        check({tag, "_wr_en"}, int'(o_wr_en), 0);
        check({tag, "_wr_slot"}, int'(o_wr_slot), 0);
        check({tag, "_wr_data"}, int'(o_wr_data), 0);
        check({tag, "_bank_clr"}, int'(o_bank_clr), 0);
        check({tag, "_mode"}, int'(o_mode), 0);
        check({tag, "_fill_cnt"}, int'(o_fill_cnt), 0);
    endtask

    initial begin
        wr_t e;
        int  ec;
        forever begin
            @(posedge clk);
            #1;
            if (o_wr_en) begin
                if (q_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got wr_en=1 slot=%0d data=%0d, expected no write (cycle %0d)",
                             o_wr_slot, o_wr_data, cyc);
                end else begin
                    e = q_wr.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_slot", int'(o_wr_slot), e.slot);
                    check("wr_data", int'(o_wr_data), e.data);
                    check("wr_fill_cnt", int'(o_fill_cnt), e.cnt);
                    check("wr_mode", int'(o_mode), e.mode);
                end
            end
            if (o_bank_clr) begin
                if (q_clr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL clr_unexpected: got bank_clr=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    ec = q_clr.pop_front();
                    check("clr_cycle", cyc, ec);
                    check("clr_fill_cnt", int'(o_fill_cnt), 0);
                    check("clr_mode", int'(o_mode), 0);
                end
            end
        end
    end

    initial begin
        int             g;
        logic [N-1:0]   pend;
        logic [N*W-1:0] pdata;
        logic           c;

        rst_n   = 1'b0;
        i_req   = '0;
        i_wdata = '0;
        i_clr   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First write, then a held 111 until the bank fills, then COMBINE hold-off.
        issue(3'b001, {4'h0, 4'h0, 4'h5}, 1'b0, g);
        repeat (3) issue(3'b111, {4'hc, 4'hb, 4'ha}, 1'b0, g);
        repeat (2) issue(3'b010, {4'h0, 4'h7, 4'h0}, 1'b0, g);
        issue(3'b010, {4'h0, 4'h7, 4'h0}, 1'b1, g);
        issue(3'b010, {4'h0, 4'h7, 4'h0}, 1'b1, g);
        issue(3'b010, {4'h0, 4'h7, 4'h0}, 1'b0, g);

        // clr beats a simultaneous request.
        issue(3'b001, {4'h0, 4'h0, 4'h3}, 1'b1, g);
        issue(3'b000, '0, 1'b0, g);

        // Zero data still occupies a slot; reset at fill_cnt=2 restarts at slot 0.
        issue(3'b001, {4'h0, 4'h0, 4'h0}, 1'b0, g);
        issue(3'b100, {4'h6, 4'h0, 4'h0}, 1'b0, g);
        @(negedge clk);
        i_req = '0;
        i_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b100, {4'h9, 4'h0, 4'h0}, 1'b0, g);
        issue(3'b000, '0, 1'b1, g);
        issue(3'b000, '0, 1'b0, g);

        // Random requesters that hold req/data until granted.
        pend  = '0;
        pdata = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdata[i*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
                end
            end
            c = ($urandom_range(0, 15) == 0);
            issue(pend, pdata, c, g);
            if (g >= 0) pend[g] = 1'b0;
        end

        repeat (3) issue(3'b000, '0, 1'b0, g);
        check("wr_queue_drained", q_wr.size(), 0);
        check("clr_queue_drained", q_clr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
